// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and the reset PC default.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int          INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word that arrives while decode is stalled.
// Loads in one cycle, pops in one cycle; flush empties it and wins over load.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               load,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (areset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else begin
      if (flush)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      else if (pop)  valid <= 1'b0;
      if (load && !flush) begin
        pc    <= load_pc;
        instr <= load_instr;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC fetch with redirect; ack->if_valid latency is one cycle.
// Decode stall parks one early word in a skid slot and suppresses new requests until it drains.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic [INSTR_W-1:0] if_instr
);

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   target;
  logic                ack;
  logic                consume;
  logic                pend_valid;
  logic [ADDR_W-1:0]   pend_pc;
  logic [INSTR_W-1:0]  pend_instr;
  logic                pend_load;
  logic                pend_pop;

  assign pc_inc    = pc + ADDR_W'(4);
  assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};
  // Acks with no request outstanding (e.g. a stale response after reset) are ignored.
  assign ack       = imem_ack && imem_req;
  assign consume   = if_valid && !stall;
  assign pend_load = (state == REQ) && ack && !redirect_valid && if_valid && stall;
  assign pend_pop  = (state == REQ) && consume && pend_valid && !redirect_valid;

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk        (clk),
    .areset     (areset),
    .load       (pend_load),
    .pop        (pend_pop),
    .flush      (redirect_valid),
    .load_pc    (pc),
    .load_instr (imem_rdata),
    .valid      (pend_valid),
    .pc         (pend_pc),
    .instr      (pend_instr)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      state       <= IDLE;
      pc          <= RESET_PC[ADDR_W-1:0];
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC[ADDR_W-1:0];
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      pc       <= target;
      // An unacked access must complete on the old address; its data is dropped in DRAIN.
      if (imem_req && !imem_ack) begin
        state <= DRAIN;
      end else begin
        state     <= REQ;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          if (ack && (!if_valid || !stall)) begin
            if_valid    <= 1'b1;
            if_pc       <= pc;
            if_pc_plus4 <= pc_inc;
            if_instr    <= imem_rdata;
            pc          <= pc_inc;
            imem_addr   <= pc_inc;
          end else if (ack) begin
            pc        <= pc_inc;
            imem_req  <= 1'b0;
            imem_addr <= pc_inc;
          end else if (consume && pend_valid) begin
            if_pc       <= pend_pc;
            if_pc_plus4 <= pend_pc + ADDR_W'(4);
            if_instr    <= pend_instr;
            imem_req    <= 1'b1;
          end else if (consume) begin
            if_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (ack) begin
            state     <= REQ;
            imem_addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch stage bench: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        areset, stall, redirect_valid, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_pc_plus4, if_instr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0040_0000), .ADDR_W(32)) dut (
    .clk            (clk),
    .areset         (areset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  // Model: words delivered to decode form a queue (front = output slot, at most one behind it).
  ent_t        q[$];
  ent_t        m_out;
  logic [31:0] m_pc, m_addr;
  bit          m_req, m_drain, m_idle;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit rv, input logic [31:0] rp,
                            input bit ak, input logic [31:0] rd);
    bit ack_eff;
    ent_t e;
    if (rst) begin
      q.delete();
      m_out   = '{32'h0, 32'h0, 32'h0};
      m_pc    = 32'h0040_0000;
      m_addr  = 32'h0040_0000;
      m_req   = 0;
      m_drain = 0;
      m_idle  = 1;
      return;
    end
    ack_eff = ak && m_req;
    if (rv) begin
      q.delete();
      m_pc   = rp & 32'hFFFF_FFFC;
      m_idle = 0;
      if (m_req && !ack_eff) begin
        m_drain = 1;
      end else begin
        m_drain = 0;
        m_req   = 1;
        m_addr  = m_pc;
      end
    end else if (m_idle) begin
      m_idle = 0;
      m_req  = 1;
      m_addr = m_pc;
    end else begin
      if (q.size() > 0 && !st) void'(q.pop_front());
      if (ack_eff) begin
        if (m_drain) begin
          m_drain = 0;
        end else begin
          e.pc    = m_pc;
          e.instr = rd;
          e.pc4   = m_pc + 32'd4;
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
      if (!m_drain) begin
        m_req  = (q.size() < 2);
        m_addr = m_pc;
      end
    end
    if (q.size() > 0) m_out = q[0];
  endtask

  task automatic compare_all();
    chk("if_valid", 32'(if_valid), 32'(q.size() > 0));
    chk("if_pc", if_pc, m_out.pc);
    chk("if_pc_plus4", if_pc_plus4, m_out.pc4);
    chk("if_instr", if_instr, m_out.instr);
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", imem_addr, m_addr);
  endtask

  // Called at a negedge: drive inputs, let the edge happen, then check at the next negedge.
  task automatic step(input bit rst, input bit st, input bit rv, input logic [31:0] rp,
                      input bit ak, input logic [31:0] rd);
    areset         = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ack       = ak;
    imem_rdata     = rd;
    @(posedge clk);
    model_step(rst, st, rv, rp, ak, rd);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit          rst, st, rv, ak;
    logic [31:0] rp;
    areset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // Reset state, then back-to-back sequential fetch.
    step(1, 0, 0, 0, 0, 0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0040_0000);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("seq_addr0", imem_addr, 32'h0040_0000);
    chk("seq_req0", 32'(imem_req), 32'd1);
    step(0, 0, 0, 0, 1, 32'hAAAA_0000);
    chk("seq_addr1", imem_addr, 32'h0040_0004);
    chk("seq_pc0", if_pc, 32'h0040_0000);
    step(0, 0, 0, 0, 1, 32'hAAAA_0001);
    chk("seq_addr2", imem_addr, 32'h0040_0008);
    chk("seq_valid1", 32'(if_valid), 32'd1);
    step(0, 0, 0, 0, 1, 32'hAAAA_0002);
    chk("seq_pc4", if_pc_plus4, 32'h0040_000C);

    // Ack under stall: word parks, request drops, word appears after stall releases.
    step(0, 1, 0, 0, 1, 32'hBBBB_0003);
    chk("stall_req0", 32'(imem_req), 32'd0);
    chk("stall_instr", if_instr, 32'hAAAA_0002);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("stall_instr_held", if_instr, 32'hAAAA_0002);
    step(0, 0, 0, 0, 0, 0);
    chk("pend_instr", if_instr, 32'hBBBB_0003);
    chk("pend_pc", if_pc, 32'h0040_000C);
    chk("pend_req", 32'(imem_req), 32'd1);

    // Redirect with request outstanding: drain old address, discard its data.
    step(0, 0, 1, 32'h0040_0103, 0, 0);
    chk("drain_addr", imem_addr, 32'h0040_0010);
    chk("drain_valid", 32'(if_valid), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_0001);
    chk("drain_next_addr", imem_addr, 32'h0040_0100);
    chk("drain_discard", 32'(if_valid), 32'd0);
    step(0, 0, 0, 0, 1, 32'hCCCC_0100);
    chk("redir_pc", if_pc, 32'h0040_0100);

    // Redirect coincident with ack.
    step(0, 0, 1, 32'h0040_0200, 1, 32'hDEAD_0002);
    chk("coinc_valid", 32'(if_valid), 32'd0);
    chk("coinc_addr", imem_addr, 32'h0040_0200);
    step(0, 0, 0, 0, 1, 32'hCCCC_0200);
    chk("coinc_instr", if_instr, 32'hCCCC_0200);

    // Wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hDEAD_0003);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 32'hEEEE_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0000_0000);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    step(0, 0, 0, 0, 1, 32'hEEEE_0000);
    chk("wrap_pc", if_pc, 32'h0000_0000);

    // Redirect while draining only retargets.
    step(0, 0, 1, 32'h0040_0300, 0, 0);
    step(0, 0, 1, 32'h0040_0404, 0, 0);
    chk("redrain_addr", imem_addr, 32'h0000_0004);
    step(0, 0, 0, 0, 1, 32'hDEAD_0004);
    chk("redrain_next", imem_addr, 32'h0040_0404);

    // Reset mid-request; late ack in IDLE is ignored.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_0005);
    chk("late_ack_valid", 32'(if_valid), 32'd0);
    chk("late_ack_addr", imem_addr, 32'h0040_0000);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    chk("post_rst_pc", if_pc, 32'h0040_0000);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 2) == 0);
      ak  = imem_req && !rst && ($urandom_range(0, 1) == 0);
      rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      step(rst, st, rv, rp, ak, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
